// File: rtl/ex_mem_pipe.sv
// ============================================================================
// Module   : ex_mem_pipe
// Purpose  : EX/MEM pipeline register with valid/flush/stall and a data-memory
//            request handshake FSM that freezes upstream on multi-cycle access.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_pipe #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int WB_W    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [WB_W-1:0]   wb_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [REG_W-1:0]  dest_reg_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              mem_ack_i,
    output logic              valid_o,
    output logic [WB_W-1:0]   wb_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [DATA_W-1:0] addr_o,
    output logic [DATA_W-1:0] write_data_o,
    output logic [REG_W-1:0]  dest_reg_o,
    output logic              mem_req_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int               CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TO  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_q, timeout_d;

    logic                valid_q, valid_d;
    logic [WB_W-1:0]     wb_q, wb_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [REG_W-1:0]    dest_q, dest_d;

    logic                busy;
    logic                hold;
    logic                memop;

    always_comb begin
        busy  = (state_q == ACCESS) & ~mem_ack_i;
        hold  = stall_i | busy;
        memop = ~hold & ~flush_i & valid_i & (mem_read_i | mem_write_i);
    end

    // Pipeline slot: hold wins over flush so a bubble never overwrites a frozen slot.
    always_comb begin
        valid_d = valid_q;
        wb_d    = wb_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dest_d  = dest_q;
        if (!hold) begin
            if (flush_i) begin
                valid_d = 1'b0;
                wb_d    = '0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
                dest_d  = '0;
            end else begin
                valid_d = valid_i;
                wb_d    = valid_i ? wb_i : '0;
                rd_d    = valid_i & mem_read_i;
                wr_d    = valid_i & mem_write_i;
                addr_d  = alu_result_i;
                wdata_d = store_data_i;
                dest_d  = dest_reg_i;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (memop) state_d = ACCESS;
            end
            ACCESS: begin
                if (mem_ack_i) begin
                    if (stall_i)    state_d = DONE;
                    else if (memop) state_d = ACCESS;
                    else            state_d = IDLE;
                end else if (cnt_q != C_TO) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == C_TO) timeout_d = 1'b1;
                end
            end
            DONE: begin
                if (!stall_i) state_d = memop ? ACCESS : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A back-to-back access re-enters ACCESS on the ack edge and gets a fresh budget.
        if (state_d == ACCESS && (state_q != ACCESS || mem_ack_i)) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
            wb_q      <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dest_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            valid_q   <= valid_d;
            wb_q      <= wb_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            dest_q    <= dest_d;
        end
    end

    assign valid_o      = valid_q;
    assign wb_o         = wb_q;
    assign mem_read_o   = rd_q;
    assign mem_write_o  = wr_q;
    assign addr_o       = addr_q;
    assign write_data_o = wdata_q;
    assign dest_reg_o   = dest_q;
    assign mem_req_o    = (state_q == ACCESS);
    assign busy_o       = busy;
    assign timeout_o    = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_pipe.sv
// ============================================================================
// Module   : tb_ex_mem_pipe
// Purpose  : Directed and randomized check of ex_mem_pipe against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_pipe;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int WB_W   = 2;
    localparam int TO     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_i, mem_read_i, mem_write_i, flush_i, stall_i, mem_ack_i;
    logic [WB_W-1:0]   wb_i;
    logic [DATA_W-1:0] alu_result_i, store_data_i;
    logic [REG_W-1:0]  dest_reg_i;
    logic              valid_o, mem_read_o, mem_write_o, mem_req_o, busy_o, timeout_o;
    logic [WB_W-1:0]   wb_o;
    logic [DATA_W-1:0] addr_o, write_data_o;
    logic [REG_W-1:0]  dest_reg_o;

    ex_mem_pipe #(
        .DATA_W(DATA_W), .REG_W(REG_W), .WB_W(WB_W), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .wb_i(wb_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i), .dest_reg_i(dest_reg_i),
        .flush_i(flush_i), .stall_i(stall_i), .mem_ack_i(mem_ack_i),
        .valid_o(valid_o), .wb_o(wb_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .addr_o(addr_o), .write_data_o(write_data_o), .dest_reg_o(dest_reg_o),
        .mem_req_o(mem_req_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: the slot contents, whether an access is outstanding, and how
    // long it has waited. A retired-but-stalled access is simply "not outstanding".
    logic              m_valid, m_rd, m_wr, m_pending, m_to;
    logic [WB_W-1:0]   m_wb;
    logic [DATA_W-1:0] m_addr, m_wdata;
    logic [REG_W-1:0]  m_dest;
    int                m_wait;
    int                req_cycles, busy_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rd = 0; m_wr = 0; m_pending = 0; m_to = 0;
        m_wb = '0; m_addr = '0; m_wdata = '0; m_dest = '0; m_wait = 0;
    endtask

    task automatic drive(input logic v, input logic [WB_W-1:0] wb, input logic rd,
                         input logic wr, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] sd, input logic [REG_W-1:0] d,
                         input logic fl, input logic st, input logic ak);
        valid_i = v; wb_i = wb; mem_read_i = rd; mem_write_i = wr;
        alu_result_i = a; store_data_i = sd; dest_reg_i = d;
        flush_i = fl; stall_i = st; mem_ack_i = ak;
    endtask

    task automatic check_regs(input string pfx);
        chk({pfx, ".valid"}, 32'(valid_o), 32'(m_valid));
        chk({pfx, ".wb"},    32'(wb_o), 32'(m_wb));
        chk({pfx, ".rd"},    32'(mem_read_o), 32'(m_rd));
        chk({pfx, ".wr"},    32'(mem_write_o), 32'(m_wr));
        chk({pfx, ".addr"},  addr_o, m_addr);
        chk({pfx, ".wdata"}, write_data_o, m_wdata);
        chk({pfx, ".dest"},  32'(dest_reg_o), 32'(m_dest));
        chk({pfx, ".req"},   32'(mem_req_o), 32'(m_pending));
        chk({pfx, ".tmo"},   32'(timeout_o), 32'(m_to));
    endtask

    // Inputs are already applied (just after a rising edge); checks combinational
    // outputs late in the cycle, advances the model, then checks registers.
    task automatic tick(input string tag);
        logic exp_busy, hold, memop;
        #3;
        exp_busy = m_pending & ~mem_ack_i;
        chk({tag, ".busy"}, 32'(busy_o), 32'(exp_busy));
        chk({tag, ".req_c"}, 32'(mem_req_o), 32'(m_pending));
        if (mem_req_o) req_cycles++;
        if (busy_o)    busy_cycles++;
        hold  = stall_i | exp_busy;
        memop = ~hold & ~flush_i & valid_i & (mem_read_i | mem_write_i);
        if (!hold) begin
            if (flush_i) begin
                m_valid = 0; m_wb = '0; m_rd = 0; m_wr = 0;
                m_addr = '0; m_wdata = '0; m_dest = '0;
            end else begin
                m_valid = valid_i;
                m_wb    = valid_i ? wb_i : '0;
                m_rd    = valid_i & mem_read_i;
                m_wr    = valid_i & mem_write_i;
                m_addr  = alu_result_i; m_wdata = store_data_i; m_dest = dest_reg_i;
            end
        end
        if (m_pending && !mem_ack_i) begin
            m_wait++;
            if (m_wait >= TO) m_to = 1;
        end else begin
            m_pending = memop;
            if (memop) m_wait = 0;
        end
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        drive(0, '0, 0, 0, '0, '0, '0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        #12;
        check_regs("reset");
        chk("reset.busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Plain ALU op
        drive(1, 2'b10, 0, 0, 32'h0000_1234, 32'h0, 5'd5, 0, 0, 0);
        tick("alu");
        chk("alu.addr_const", addr_o, 32'h0000_1234);
        chk("alu.dest_const", 32'(dest_reg_o), 32'd5);
        chk("alu.valid_const", 32'(valid_o), 32'd1);

        // Load, ack in third ACCESS cycle; next instr (ALU op) waits in EX
        drive(1, 2'b11, 1, 0, 32'h40, 32'h0, 5'd7, 0, 0, 0);
        tick("lw.cap");
        req_cycles = 0; busy_cycles = 0;
        drive(1, 2'b01, 0, 0, 32'h88, 32'h9, 5'd3, 0, 0, 0);
        tick("lw.w1");
        chk("lw.hold_addr", addr_o, 32'h40);
        tick("lw.w2");
        mem_ack_i = 1'b1;
        tick("lw.ack");
        chk("lw.next_addr", addr_o, 32'h88);
        chk("lw.req_cycles", 32'(req_cycles), 32'd3);
        chk("lw.busy_cycles", 32'(busy_cycles), 32'd2);
        drive(0, '0, 0, 0, '0, '0, '0, 0, 0, 0);
        tick("lw.idle");

        // Flush a valid store
        drive(1, 2'b11, 0, 1, 32'hABCD, 32'h5555, 5'd9, 1, 0, 0);
        tick("flush");
        chk("flush.wr_const", 32'(mem_write_o), 32'd0);
        chk("flush.addr_const", addr_o, 32'd0);
        drive(0, '0, 0, 0, '0, '0, '0, 0, 0, 0);
        tick("flush.noreq");

        // Stall over the ack: retire into the held state, then a store follows
        drive(1, 2'b01, 1, 0, 32'h100, 32'h0, 5'd4, 0, 0, 0);
        tick("st.cap");
        drive(1, 2'b00, 0, 1, 32'h200, 32'hDEAD_BEEF, 5'd0, 0, 1, 0);
        tick("st.w1");
        mem_ack_i = 1'b1;
        tick("st.ack");
        mem_ack_i = 1'b0;
        tick("st.done");
        chk("st.done_req", 32'(mem_req_o), 32'd0);
        chk("st.done_addr", addr_o, 32'h100);
        stall_i = 1'b0;
        tick("st.sw");
        chk("st.sw_wr", 32'(mem_write_o), 32'd1);
        chk("st.sw_req", 32'(mem_req_o), 32'd1);
        drive(0, '0, 0, 0, '0, '0, '0, 0, 0, 1);
        tick("st.swack");

        // Timeout: store never acked for 5 cycles, acked in the 6th
        drive(1, 2'b00, 0, 1, 32'h300, 32'h77, 5'd0, 0, 0, 0);
        tick("to.cap");
        drive(0, '0, 0, 0, '0, '0, '0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            tick("to.wait");
            if (i == 3) chk("to.before", 32'(timeout_o), 32'd0);
            if (i == 4) chk("to.after4", 32'(timeout_o), 32'd1);
        end
        mem_ack_i = 1'b1;
        tick("to.ack");
        mem_ack_i = 1'b0;
        tick("to.idle");
        chk("to.sticky", 32'(timeout_o), 32'd1);
        chk("to.idle_req", 32'(mem_req_o), 32'd0);

        // Asynchronous reset in the middle of an ACCESS cycle
        drive(1, 2'b10, 1, 0, 32'h400, 32'h0, 5'd2, 0, 0, 0);
        tick("ar.cap");
        drive(0, '0, 0, 0, '0, '0, '0, 0, 0, 0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("ar.req", 32'(mem_req_o), 32'd0);
        chk("ar.busy", 32'(busy_o), 32'd0);
        chk("ar.tmo", 32'(timeout_o), 32'd0);
        chk("ar.valid", 32'(valid_o), 32'd0);
        chk("ar.addr", addr_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        tick("ar.idle");

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom, $urandom, 5'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) != 0);
            tick("rnd");
            if (n == 250) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
